// File: rtl/calc_pkg.sv
// Shared calculator/display definitions: glyph codes, digit count,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and the scan slot type.
package calc_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [3:0] GLYPH_E     = 4'hE;
  localparam logic [3:0] GLYPH_C     = 4'hC;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    SLOT0, SLOT1, SLOT2, SLOT3, SLOT4, SLOT5, SLOT6, SLOT7
  } slot_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph decoder: 4-bit glyph code to active-low segment pattern.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0:        pattern = SEG_0;
      4'h1:        pattern = SEG_1;
      4'h2:        pattern = SEG_2;
      4'h3:        pattern = SEG_3;
      4'h4:        pattern = SEG_4;
      4'h5:        pattern = SEG_5;
      4'h6:        pattern = SEG_6;
      4'h7:        pattern = SEG_7;
      4'h8:        pattern = SEG_8;
      4'h9:        pattern = SEG_9;
      4'hA:        pattern = SEG_A;
      4'hB:        pattern = SEG_B;
      GLYPH_C:     pattern = SEG_C;
      4'hD:        pattern = SEG_D;
      GLYPH_E:     pattern = SEG_E;
      GLYPH_BLANK: pattern = SEG_BLANK;
      default:     pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// 8-digit display receiver: latches digit writes and time-multiplexes them
// onto a shared common-anode 7-segment bus with optional leading-zero blanking.
module display_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] display_val,
  input  logic [2:0] display_idx,
  input  logic       display_wr,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  slot_t            pos, pos_next;
  logic [3:0]       digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic             lead_zero;
  logic [3:0]       shown_code;
  logic [6:0]       pattern;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pos <= SLOT0;
    else     pos <= pos_next;
  end

  always_comb begin
    pos_next = pos;
    if (tick) pos_next = slot_t'(pos + 3'd1);
  end

  // clr wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 4'h0;
    end else if (display_wr) begin
      digit[display_idx] <= display_val;
    end
  end

  // A zero is leading while everything to its left is zero or blank
  always_comb begin
    lead_zero = 1'b1;
    lz_blank  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (BLANK_LZ && (k < NUM_DIGITS - 1) && lead_zero && (digit[k] == 4'h0))
        lz_blank[k] = 1'b1;
      lead_zero = lead_zero && ((digit[k] == 4'h0) || (digit[k] == GLYPH_BLANK));
    end
  end

  assign shown_code = lz_blank[pos] ? GLYPH_BLANK : digit[pos];

  seg7_decoder u_dec (
    .code    (shown_code),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      an         <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (pos == SLOT7);
      if (tick) begin
        seg <= pattern;
        an  <= ~(8'h01 << pos);
      end
    end
  end

endmodule
